// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the two-master BRAM arbiter.
// Covers the 32-bit x 2048-word single-port block RAM.
package bram_arb_pkg;

    localparam int P_DWIDTH     = 32;
    localparam int P_EWIDTH     = P_DWIDTH / 8;
    localparam int P_AWIDTH     = 11;
    localparam int P_RD_LATENCY = 1;

    typedef enum logic {
        ID_M0 = 1'b0,
        ID_M1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester preferred on a tie
// and flips to the loser whenever a transfer happens.
module bram_rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       fire_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    req_id_e ptr_q;
    req_id_e ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = (ptr_q == ID_M1) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (fire_i) begin
            ptr_d = gnt_o[1] ? ID_M0 : ID_M1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= ID_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bram_arb_2to1.sv
// Shares one registered BRAM port between two masters and steers each read
// completion back to its issuer through a tag pipeline matched to BRAM latency.
module bram_arb_2to1
    import bram_arb_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                M0_REQ,
    input  logic [P_EWIDTH-1:0] M0_WE,
    input  logic [P_AWIDTH-1:0] M0_ADDR,
    input  logic [P_DWIDTH-1:0] M0_DIN,
    output logic                M0_ACK,
    output logic                M0_RVALID,
    output logic [P_DWIDTH-1:0] M0_DOUT,
    input  logic                M1_REQ,
    input  logic [P_EWIDTH-1:0] M1_WE,
    input  logic [P_AWIDTH-1:0] M1_ADDR,
    input  logic [P_DWIDTH-1:0] M1_DIN,
    output logic                M1_ACK,
    output logic                M1_RVALID,
    output logic [P_DWIDTH-1:0] M1_DOUT,
    output logic                BRAM_EN,
    output logic [P_EWIDTH-1:0] BRAM_WE,
    output logic [P_AWIDTH-1:0] BRAM_ADDR,
    output logic [P_DWIDTH-1:0] BRAM_DIN,
    input  logic [P_DWIDTH-1:0] BRAM_DOUT
);

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0]          ack;
    logic                fire;
    logic                arb_ptr;
    req_id_e             win_id;
    logic [P_EWIDTH-1:0] win_we;
    logic [P_AWIDTH-1:0] win_addr;
    logic [P_DWIDTH-1:0] win_din;

    logic                bram_en_q,   bram_en_d;
    logic [P_EWIDTH-1:0] bram_we_q,   bram_we_d;
    logic [P_AWIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [P_DWIDTH-1:0] bram_din_q,  bram_din_d;

    rd_tag_t                  new_tag;
    rd_tag_t [P_RD_LATENCY:0] tag_q;
    rd_tag_t [P_RD_LATENCY:0] tag_d;
    rd_tag_t                  tag_out;

    assign req = {M1_REQ, M0_REQ};

    bram_rr_arb2 u_arb (
        .clk_i  (CLK),
        .rst_i  (RST),
        .req_i  (req),
        .fire_i (fire),
        .gnt_o  (gnt),
        .ptr_o  (arb_ptr)
    );

    // Grants are masked during reset so no command is consumed and then dropped.
    assign ack    = gnt & {2{~RST}};
    assign fire   = |ack;
    assign M0_ACK = ack[0];
    assign M1_ACK = ack[1];

    assign win_id = (&req) ? req_id_e'(arb_ptr) : (req[1] ? ID_M1 : ID_M0);

    always_comb begin
        win_we   = M0_WE;
        win_addr = M0_ADDR;
        win_din  = M0_DIN;
        if (win_id == ID_M1) begin
            win_we   = M1_WE;
            win_addr = M1_ADDR;
            win_din  = M1_DIN;
        end
    end

    always_comb begin
        bram_en_d   = fire;
        bram_we_d   = fire ? win_we   : '0;
        bram_addr_d = fire ? win_addr : bram_addr_q;
        bram_din_d  = fire ? win_din  : bram_din_q;
    end

    // One stage for the registered BRAM port plus one per cycle of RAM latency.
    always_comb begin
        new_tag.valid = fire && (win_we == '0);
        new_tag.id    = win_id;
        tag_d         = {tag_q[P_RD_LATENCY-1:0], new_tag};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            tag_q       <= '0;
        end else begin
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            tag_q       <= tag_d;
        end
    end

    assign BRAM_EN   = bram_en_q;
    assign BRAM_WE   = bram_we_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_DIN  = bram_din_q;

    assign tag_out   = tag_q[P_RD_LATENCY];
    assign M0_RVALID = tag_out.valid && (tag_out.id == ID_M0);
    assign M1_RVALID = tag_out.valid && (tag_out.id == ID_M1);
    assign M0_DOUT   = BRAM_DOUT;
    assign M1_DOUT   = BRAM_DOUT;

endmodule

// File: tb/tb_bram_arb_2to1.sv
// Directed bench for bram_arb_2to1 with a behavioural 1-cycle-latency BRAM.
// Inputs change 1 time unit after each rising edge; outputs are checked 2 units later.
module tb_bram_arb_2to1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [10:0] m0_addr, m1_addr;
    logic [31:0] m0_din, m1_din;
    logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [31:0] m0_dout, m1_dout;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [10:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] mem [2048];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural single-port RAM: ena sampled on an edge, douta updated on that edge.
    always @(posedge clk) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr];
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
        end
    end

    bram_arb_2to1 dut (
        .CLK       (clk),
        .RST       (rst),
        .M0_REQ    (m0_req),
        .M0_WE     (m0_we),
        .M0_ADDR   (m0_addr),
        .M0_DIN    (m0_din),
        .M0_ACK    (m0_ack),
        .M0_RVALID (m0_rvalid),
        .M0_DOUT   (m0_dout),
        .M1_REQ    (m1_req),
        .M1_WE     (m1_we),
        .M1_ADDR   (m1_addr),
        .M1_DIN    (m1_din),
        .M1_ACK    (m1_ack),
        .M1_RVALID (m1_rvalid),
        .M1_DOUT   (m1_dout),
        .BRAM_EN   (bram_en),
        .BRAM_WE   (bram_we),
        .BRAM_ADDR (bram_addr),
        .BRAM_DIN  (bram_din),
        .BRAM_DOUT (bram_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        int i0, i1, idx;
        logic exp0;

        rst     = 1'b1;
        m0_req  = 1'b1; m0_we = 4'hF; m0_addr = 11'h005; m0_din = 32'hDEADBEEF;
        m1_req  = 1'b0; m1_we = 4'h0; m1_addr = 11'h000; m1_din = 32'h0;

        // Reset held 3 cycles with M0 requesting.
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk("rst_m0_ack", m0_ack, 0);
            chk("rst_bram_en", bram_en, 0);
        end
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_bram_din", bram_din, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);

        // First cycle out of reset: M0 write 0x005 accepted at once.
        tick(); rst = 1'b0; settle();
        chk("post_rst_m0_ack", m0_ack, 1);
        chk("post_rst_m1_ack", m1_ack, 0);

        tick(); m0_we = 4'h0; settle();
        chk("wr_bram_en", bram_en, 1);
        chk("wr_bram_we", bram_we, 32'hF);
        chk("wr_bram_addr", bram_addr, 32'h005);
        chk("wr_bram_din", bram_din, 32'hDEADBEEF);
        chk("rd0_ack", m0_ack, 1);

        tick(); m0_req = 1'b0; settle();
        chk("rd0_bram_en", bram_en, 1);
        chk("rd0_bram_we", bram_we, 0);
        chk("rd0_early_rvalid", m0_rvalid, 0);

        tick(); settle();
        chk("rd0_rvalid", m0_rvalid, 1);
        chk("rd0_dout", m0_dout, 32'hDEADBEEF);
        chk("rd0_m1_rvalid", m1_rvalid, 0);
        chk("idle_bram_en", bram_en, 0);
        chk("idle_bram_addr_hold", bram_addr, 32'h005);

        tick(); settle();
        chk("rd0_rvalid_once", m0_rvalid, 0);

        // M1 partial write then read-back.
        m1_req = 1'b1; m1_we = 4'h3; m1_addr = 11'h005; m1_din = 32'h00001234; settle();
        chk("be_wr_m1_ack", m1_ack, 1);
        chk("be_wr_m0_ack", m0_ack, 0);
        tick(); m1_we = 4'h0; settle();
        chk("be_rd_m1_ack", m1_ack, 1);
        tick(); m1_req = 1'b0; settle();
        tick(); settle();
        chk("be_rvalid", m1_rvalid, 1);
        chk("be_dout", m1_dout, 32'hDEAD1234);
        chk("be_m0_rvalid", m0_rvalid, 0);

        // Preload by M1 so the pointer ends preferring M0.
        tick();
        m1_req = 1'b1; m1_we = 4'hF;
        for (int k = 0; k < 8; k++) begin
            m1_addr = (k < 4) ? 11'(32'h001 + k) : 11'(32'h101 + k - 4);
            m1_din  = (k < 4) ? 32'hA0000001 + k : 32'hB0000101 + k - 4;
            settle();
            chk("pre_m1_ack", m1_ack, 1);
            tick();
        end
        m1_req = 1'b0; m1_we = 4'h0;
        tick(); tick();

        // Contention: both hold requests; grants must alternate starting with M0.
        i0 = 0; i1 = 0;
        for (int k = 0; k < 10; k++) begin
            m0_req  = (i0 < 4); m0_addr = 11'(32'h001 + i0); m0_we = 4'h0;
            m1_req  = (i1 < 4); m1_addr = 11'(32'h101 + i1); m1_we = 4'h0;
            settle();
            if (k < 8) begin
                chk($sformatf("cont_m0_ack[%0d]", k), m0_ack, (k % 2 == 0));
                chk($sformatf("cont_m1_ack[%0d]", k), m1_ack, (k % 2 == 1));
            end
            chk($sformatf("cont_bram_en[%0d]", k), bram_en, (k >= 1 && k <= 8));
            if (k >= 2) begin
                idx  = (k - 2) / 2;
                exp0 = ((k - 2) % 2 == 0);
                chk($sformatf("cont_m0_rvalid[%0d]", k), m0_rvalid, exp0);
                chk($sformatf("cont_m1_rvalid[%0d]", k), m1_rvalid, !exp0);
                if (exp0) chk($sformatf("cont_m0_dout[%0d]", k), m0_dout, 32'hA0000001 + idx);
                else      chk($sformatf("cont_m1_dout[%0d]", k), m1_dout, 32'hB0000101 + idx);
            end else begin
                chk($sformatf("cont_rvalid_idle[%0d]", k), {m1_rvalid, m0_rvalid}, 0);
            end
            if (m0_ack) i0++;
            if (m1_ack) i1++;
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Back-to-back reads from M1 alone.
        for (int k = 0; k < 7; k++) begin
            m1_req = (k < 4); m1_addr = 11'(32'h101 + k); m1_we = 4'h0;
            settle();
            if (k < 4) chk($sformatf("b2b_ack[%0d]", k), m1_ack, 1);
            if (k >= 2 && k < 6) begin
                chk($sformatf("b2b_rvalid[%0d]", k), m1_rvalid, 1);
                chk($sformatf("b2b_dout[%0d]", k), m1_dout, 32'hB0000101 + k - 2);
            end else begin
                chk($sformatf("b2b_rvalid_idle[%0d]", k), m1_rvalid, 0);
            end
            tick();
        end
        m1_req = 1'b0;

        // Reset arrives the edge after a read is accepted: the read must vanish.
        m0_req = 1'b1; m0_we = 4'h0; m0_addr = 11'h001; settle();
        chk("mid_rst_ack", m0_ack, 1);
        tick(); m0_req = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0; settle();
        chk("mid_rst_bram_en", bram_en, 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mid_rst_m0_rvalid[%0d]", k), m0_rvalid, 0);
            chk($sformatf("mid_rst_m1_rvalid[%0d]", k), m1_rvalid, 0);
            tick(); settle();
        end

        // Recovery: a fresh read completes normally.
        m1_req = 1'b1; m1_addr = 11'h104; m1_we = 4'h0; settle();
        chk("recover_ack", m1_ack, 1);
        tick(); m1_req = 1'b0;
        tick(); settle();
        chk("recover_rvalid", m1_rvalid, 1);
        chk("recover_dout", m1_dout, 32'hB0000104);
        chk("recover_m0_rvalid", m0_rvalid, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
